// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: expands START/STOP/WRITE/ACK/NACK into bit-stage requests (WRITE order set by I2C_MASTER_BYTE_LSB_FIRST_EN).
// Latency: one cycle from go to the first bit_go; each bit is a four-phase bit_go/bit_finish exchange.
// Backpressure: waits on bit_finish for up to TIMEOUT_CYCLES per phase; finish is held until go drops.
module i2c_master_byte #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] command,
  input  logic [7:0] data_in,
  output logic       finish,
  output logic       error,
  output logic       busy,
  output logic       bit_go,
  output logic [2:0] bit_command,
  input  logic       bit_finish
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0]  CMD_START = 3'b001;
  localparam logic [2:0]  CMD_STOP  = 3'b010;
  localparam logic [2:0]  CMD_WRITE = 3'b011;
  localparam logic [2:0]  CMD_ACK   = 3'b100;
  localparam logic [2:0]  CMD_NACK  = 3'b101;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] wait_q, wait_d;
  logic        error_q, error_d;

  logic [2:0]  bit_idx;
  logic        tx_bit;
  logic [2:0]  bit_code;
  logic        last_bit;
  logic        cmd_legal;
  logic        wait_expired;

  always_comb begin
`ifdef I2C_MASTER_BYTE_LSB_FIRST_EN
    bit_idx = cnt_q;
`else
    bit_idx = 3'd7 - cnt_q;
`endif
    tx_bit       = data_q[bit_idx];
    last_bit     = (cmd_q != CMD_WRITE) || (cnt_q == 3'd7);
    cmd_legal    = (command >= CMD_START) && (command <= CMD_NACK);
    wait_expired = (wait_q == WAIT_LAST);
    case (cmd_q)
      CMD_START: bit_code = 3'b010;
      CMD_STOP:  bit_code = 3'b011;
      CMD_WRITE: bit_code = {2'b10, tx_bit};
      CMD_ACK:   bit_code = 3'b110;
      CMD_NACK:  bit_code = 3'b111;
      default:   bit_code = 3'b000;
    endcase
  end

  // wait_d defaults to zero so any state change clears the wait counter.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    wait_d  = 16'd0;
    case (state_q)
      IDLE: begin
        if (go) begin
          cmd_d   = command;
          data_d  = data_in;
          cnt_d   = 3'd0;
          error_d = !cmd_legal;
          state_d = cmd_legal ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (bit_finish) begin
          state_d = RELEASE;
        end else if (wait_expired) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RELEASE: begin
        if (!bit_finish) begin
          if (last_bit) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (wait_expired) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        if (!go) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 3'd0;
      data_q  <= 8'd0;
      cnt_q   <= 3'd0;
      wait_q  <= 16'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  // Outputs are gated by reset so they read idle for the whole reset window.
  always_comb begin
    busy        = !reset && (state_q != IDLE);
    finish      = !reset && (state_q == DONE);
    error       = !reset && error_q;
    bit_go      = !reset && (state_q == ISSUE);
    bit_command = (!reset && (state_q == ISSUE || state_q == RELEASE)) ? bit_code : 3'b000;
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: directed and random byte operations against a bit-stage responder and a reference sequence model.
module tb_i2c_master_byte;

  localparam int TO = 16;
`ifdef I2C_MASTER_BYTE_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [2:0] command = 3'd0;
  logic [7:0] data_in = 8'd0;
  logic       finish, error, busy, bit_go, bit_finish;
  logic [2:0] bit_command;

  int checks = 0;
  int errors = 0;

  bit         model_en = 1'b1;
  int         resp_dly = 5;
  int         rel_dly = 1;
  int         bits_done = 0;
  int         unstable = 0;
  int         m_cnt = 0;
  logic [2:0] m_held = 3'd0;
  logic [2:0] seen[$];

  logic [2:0] exp_seq[$];
  logic       exp_err;

  i2c_master_byte #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(reset), .go(go), .command(command), .data_in(data_in),
    .finish(finish), .error(error), .busy(busy), .bit_go(bit_go),
    .bit_command(bit_command), .bit_finish(bit_finish)
  );

  always #5 clk = ~clk;

  // Bit-stage responder: raises bit_finish resp_dly cycles into a request, drops it rel_dly cycles after bit_go falls.
  initial begin
    bit_finish = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!model_en || reset) begin
        bit_finish = 1'b0;
        m_cnt = 0;
      end else if (!bit_finish) begin
        if (bit_go) begin
          if (m_cnt == 0) begin
            seen.push_back(bit_command);
            m_held = bit_command;
          end else if (bit_command !== m_held) begin
            unstable++;
          end
          m_cnt++;
          if (m_cnt >= resp_dly) begin
            bit_finish = 1'b1;
            m_cnt = 0;
            bits_done++;
          end
        end else begin
          m_cnt = 0;
        end
      end else if (!bit_go) begin
        m_cnt++;
        if (m_cnt >= rel_dly) begin
          bit_finish = 1'b0;
          m_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit codes derived directly from the command table.
  task automatic build_expected(input logic [2:0] cmd, input logic [7:0] d);
    exp_seq.delete();
    exp_err = 1'b0;
    case (cmd)
      3'd1: exp_seq.push_back(3'b010);
      3'd2: exp_seq.push_back(3'b011);
      3'd3: for (int k = 0; k < 8; k++)
              exp_seq.push_back(LSB_FIRST ? (3'd4 + {2'b00, d[k]}) : (3'd4 + {2'b00, d[7-k]}));
      3'd4: exp_seq.push_back(3'b110);
      3'd5: exp_seq.push_back(3'b111);
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic do_op(input logic [2:0] cmd, input logic [7:0] d, output int cyc);
    seen.delete();
    chk("pre_finish_low", finish, 1'b0);
    go = 1'b1;
    command = cmd;
    data_in = d;
    tick();
    cyc = 1;
    if (cmd >= 3'd1 && cmd <= 3'd5) chk("error_cleared", error, 1'b0);
    command = 3'($urandom);
    data_in = 8'($urandom);
    while (!finish && cyc < 600) begin
      tick();
      cyc++;
    end
    chk("finish_seen", finish, 1'b1);
  endtask

  task automatic verify(input string tag);
    logic [2:0] obs;
    chk({tag, "_len"}, seen.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size(); k++) begin
      obs = (k < seen.size()) ? seen[k] : 3'bxxx;
      chk($sformatf("%s_bit%0d", tag, k), obs, exp_seq[k]);
    end
    chk({tag, "_error"}, error, exp_err);
  endtask

  task automatic release_op();
    int n0;
    n0 = seen.size();
    repeat (3) tick();
    chk("finish_held", finish, 1'b1);
    chk("no_retrigger", seen.size(), n0);
    go = 1'b0;
    tick();
    chk("finish_drop", finish, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int cyc;
    int n;
    logic [2:0] a5_exp [8];
    logic [2:0] rc;
    logic [7:0] rd;
    a5_exp = '{3'b101, 3'b100, 3'b101, 3'b100, 3'b100, 3'b101, 3'b100, 3'b101};

    // Reset state, with go asserted to show it is ignored.
    reset = 1'b1;
    go = 1'b1;
    command = 3'd3;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_bit_go", bit_go, 1'b0);
    chk("rst_bit_cmd", bit_command, 3'b000);
    go = 1'b0;
    reset = 1'b0;
    tick();

    // WRITE 0xA5 with a 5-cycle bit stage.
    resp_dly = 5;
    rel_dly = 1;
    do_op(3'd3, 8'hA5, cyc);
    chk("a5_len", seen.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("a5_bit%0d", k), (k < seen.size()) ? seen[k] : 3'bxxx, a5_exp[k]);
    chk("a5_error", error, 1'b0);
    release_op();

    // START then STOP: one pulse each.
    build_expected(3'd1, 8'h00);
    do_op(3'd1, 8'h00, cyc);
    verify("start");
    release_op();
    build_expected(3'd2, 8'h00);
    do_op(3'd2, 8'h00, cyc);
    verify("stop");
    release_op();

    // Illegal code 110.
    do_op(3'd6, 8'h00, cyc);
    chk("illegal_fast", cyc <= 2, 1'b1);
    chk("illegal_error", error, 1'b1);
    chk("illegal_no_pulse", seen.size(), 0);
    release_op();

    // Legal op after an error clears error on accept.
    build_expected(3'd4, 8'h00);
    do_op(3'd4, 8'h00, cyc);
    verify("ack_after_err");
    release_op();

    // Timeout with bit_finish held low.
    model_en = 1'b0;
    go = 1'b1;
    command = 3'd3;
    data_in = 8'($urandom);
    n = 0;
    while (!bit_go && n < 10) begin tick(); n++; end
    chk("to_bit_go_rise", bit_go, 1'b1);
    n = 0;
    while (bit_go && n < 40) begin tick(); n++; end
    chk("to_within_17", (n >= 1 && n <= 17), 1'b1);
    chk("to_finish", finish, 1'b1);
    chk("to_error", error, 1'b1);
    release_op();
    model_en = 1'b1;

    // Reset after the third bit of WRITE 0xFF, then WRITE 0x01.
    resp_dly = 2;
    seen.delete();
    bits_done = 0;
    go = 1'b1;
    command = 3'd3;
    data_in = 8'hFF;
    n = 0;
    while (bits_done < 3 && n < 200) begin tick(); n++; end
    chk("rst_mid_reached", bits_done >= 3, 1'b1);
    reset = 1'b1;
    go = 1'b0;
    tick();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_bit_go", bit_go, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_bit_go", bit_go, 1'b0);
    tick();
    build_expected(3'd3, 8'h01);
    do_op(3'd3, 8'h01, cyc);
    verify("w01");
    release_op();

    // Random operations including illegal codes.
    for (int i = 0; i < 20; i++) begin
      rc = 3'($urandom);
      rd = 8'($urandom);
      resp_dly = $urandom_range(1, 4);
      rel_dly = $urandom_range(1, 3);
      build_expected(rc, rd);
      do_op(rc, rd, cyc);
      verify($sformatf("rnd%0d_c%0d", i, rc));
      release_op();
    end

    chk("cmd_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
